// File: rtl/serial_addsub.sv
// Digit-serial N-bit adder/subtractor: one DIGIT-wide ripple slice, LSB first,
// with a registered carry/borrow and a start/busy/done handshake.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             a_ns,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int C     = WIDTH / DIGIT;
  localparam int CNT_W = (C > 1) ? $clog2(C) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(C - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  r_sh_q, r_sh_d;
  logic              carry_q, carry_d;
  logic              add_q, add_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [DIGIT+1:0]  sl;
  logic [WIDTH-1:0]  r_next;
  logic              load;

  // Returns {carry into digit MSB, carry/borrow out, result digit}.
  // Subtract is a genuine borrow chain, not an inverted carry.
  function automatic logic [DIGIT+1:0] slice(input logic [DIGIT-1:0] x,
                                             input logic [DIGIT-1:0] y,
                                             input logic c,
                                             input logic add);
    logic [DIGIT:0]   ch;
    logic [DIGIT-1:0] d;
    ch[0] = c;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = x[i] ^ y[i] ^ ch[i];
      if (add) ch[i+1] = (x[i] & y[i]) | (ch[i] & (x[i] ^ y[i]));
      else     ch[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & ch[i]);
    end
    return {ch[DIGIT-1], ch[DIGIT], d};
  endfunction

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    carry_d = carry_q;
    add_d   = add_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    sl     = slice(a_sh_q[DIGIT-1:0], b_sh_q[DIGIT-1:0], carry_q, add_q);
    r_next = WIDTH'({sl[DIGIT-1:0], r_sh_q} >> DIGIT);
    load   = start && (state_q != RUN);

    case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        r_sh_d  = r_next;
        carry_d = sl[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          s_d     = r_next;
          cout_d  = sl[DIGIT];
          ovf_d   = sl[DIGIT+1] ^ sl[DIGIT];
          zero_d  = (r_next == '0);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Accepted in IDLE and in DONE, so a held start gives back-to-back ops.
    if (load) begin
      a_sh_d  = a;
      b_sh_d  = b;
      r_sh_d  = '0;
      carry_d = cin;
      add_d   = a_ns;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      add_q   <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      carry_q <= carry_d;
      add_q   <= add_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (8/1, 8/4, 16/2) share stimulus;
// table vectors, a random sweep against a +/- model, and handshake/reset sequences.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] a_i, b_i;
  logic        cin_i, ans_i;

  logic       busy_a, done_a, cout_a, ovf_a, zero_a;
  logic [7:0] s_a;
  logic       busy_b, done_b, cout_b, ovf_b, zero_b;
  logic [7:0] s_b;
  logic       busy_c, done_c, cout_c, ovf_c, zero_c;
  logic [15:0] s_c;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst), .start(start_i), .a(a_i[7:0]), .b(b_i[7:0]),
    .cin(cin_i), .a_ns(ans_i), .busy(busy_a), .done(done_a), .s(s_a),
    .cout(cout_a), .ovf(ovf_a), .zero(zero_a));

  serial_addsub #(.WIDTH(8), .DIGIT(4)) u84 (
    .clk(clk), .rst(rst), .start(start_i), .a(a_i[7:0]), .b(b_i[7:0]),
    .cin(cin_i), .a_ns(ans_i), .busy(busy_b), .done(done_b), .s(s_b),
    .cout(cout_b), .ovf(ovf_b), .zero(zero_b));

  serial_addsub #(.WIDTH(16), .DIGIT(2)) u16 (
    .clk(clk), .rst(rst), .start(start_i), .a(a_i), .b(b_i),
    .cin(cin_i), .a_ns(ans_i), .busy(busy_c), .done(done_c), .s(s_c),
    .cout(cout_c), .ovf(ovf_c), .zero(zero_c));

  int errors = 0;
  int checks = 0;

  int W  [3] = '{8, 8, 16};
  int CY [3] = '{8, 2, 8};

  logic        dn [3], bz [3], co [3], ov [3], zr [3];
  logic [15:0] so [3];
  int          lat [3], bcnt [3];
  logic [15:0] gs [3];
  logic        gc [3], go [3], gz [3];

  typedef struct {
    logic [15:0] a, b;
    logic        cin, ans;
    logic [7:0]  s;
    logic        cout, ovf, zero;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input int w, input logic [15:0] ta, input logic [15:0] tb_,
                                input logic tc, input logic tn, output logic [15:0] es,
                                output logic ec, output logic eo, output logic ez);
    int mask, av, bv, r, sa, sb, sr;
    mask = (1 << w) - 1;
    av = int'(ta) & mask;
    bv = int'(tb_) & mask;
    if (tn) begin
      r  = av + bv + int'(tc);
      ec = 1'((r >> w) & 1);
    end else begin
      r  = av - bv - int'(tc);
      ec = (av < bv + int'(tc));
    end
    es = 16'(r & mask);
    sa = (av >> (w - 1)) & 1;
    sb = (bv >> (w - 1)) & 1;
    sr = (int'(es) >> (w - 1)) & 1;
    eo = tn ? ((sa == sb) && (sr != sa)) : ((sa != sb) && (sr != sa));
    ez = (es == 16'd0);
  endfunction

  task automatic sample;
    dn[0] = done_a; bz[0] = busy_a; so[0] = {8'h00, s_a}; co[0] = cout_a; ov[0] = ovf_a; zr[0] = zero_a;
    dn[1] = done_b; bz[1] = busy_b; so[1] = {8'h00, s_b}; co[1] = cout_b; ov[1] = ovf_b; zr[1] = zero_b;
    dn[2] = done_c; bz[2] = busy_c; so[2] = s_c;          co[2] = cout_c; ov[2] = ovf_c; zr[2] = zero_c;
  endtask

  task automatic record(input int k);
    sample();
    for (int i = 0; i < 3; i++) begin
      if (bz[i] && lat[i] < 0) bcnt[i]++;
      if (dn[i] && lat[i] < 0) begin
        lat[i] = k; gs[i] = so[i]; gc[i] = co[i]; go[i] = ov[i]; gz[i] = zr[i];
      end
    end
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic tn);
    @(negedge clk);
    a_i = ta; b_i = tb_; cin_i = tc; ans_i = tn; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1; bcnt[i] = 0; gs[i] = 16'hDEAD; gc[i] = 1'bx; go[i] = 1'bx; gz[i] = 1'bx;
    end
    record(0);
    for (int k = 1; k <= 20 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); k++) begin
      @(posedge clk); #1;
      record(k);
    end
  endtask

  task automatic check_timing;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("latency[%0d]", i), 32'(lat[i]), 32'(CY[i]));
      chk($sformatf("busy_cycles[%0d]", i), 32'(bcnt[i]), 32'(CY[i]));
    end
  endtask

  task automatic check_model(input int i, input logic [15:0] ta, input logic [15:0] tb_,
                             input logic tc, input logic tn);
    logic [15:0] es;
    logic        ec, eo, ez;
    model(W[i], ta, tb_, tc, tn, es, ec, eo, ez);
    chk($sformatf("s[%0d] %h%s%h", i, ta, tn ? "+" : "-", tb_), 32'(gs[i]), 32'(es));
    chk($sformatf("cout[%0d]", i), 32'(gc[i]), 32'(ec));
    chk($sformatf("ovf[%0d]", i), 32'(go[i]), 32'(eo));
    chk($sformatf("zero[%0d]", i), 32'(gz[i]), 32'(ez));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int bad;

    tbl[0]  = '{16'd200,  16'd100,  1'b0, 1'b1, 8'd44,  1'b1, 1'b0, 1'b0};
    tbl[1]  = '{16'd127,  16'd1,    1'b0, 1'b1, 8'h80,  1'b0, 1'b1, 1'b0};
    tbl[2]  = '{16'h0080, 16'd1,    1'b0, 1'b0, 8'h7F,  1'b0, 1'b1, 1'b0};
    tbl[3]  = '{16'd5,    16'd7,    1'b0, 1'b0, 8'hFE,  1'b1, 1'b0, 1'b0};
    tbl[4]  = '{16'd3,    16'd2,    1'b1, 1'b0, 8'h00,  1'b0, 1'b0, 1'b1};
    tbl[5]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b1, 8'h01,  1'b1, 1'b0, 1'b0};
    tbl[6]  = '{16'h0080, 16'h0080, 1'b0, 1'b1, 8'h00,  1'b1, 1'b1, 1'b1};
    tbl[7]  = '{16'd0,    16'd0,    1'b1, 1'b0, 8'hFF,  1'b1, 1'b0, 1'b0};
    tbl[8]  = '{16'h007F, 16'h00FF, 1'b0, 1'b0, 8'h80,  1'b1, 1'b1, 1'b0};
    tbl[9]  = '{16'd0,    16'd0,    1'b0, 1'b1, 8'h00,  1'b0, 1'b0, 1'b1};
    tbl[10] = '{16'h0055, 16'h00AA, 1'b1, 1'b1, 8'h00,  1'b1, 1'b0, 1'b1};

    rst = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; ans_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_8", {20'd0, busy_a, done_a, s_a, cout_a, ovf_a, zero_a}, 32'd0);
    chk("reset_outputs_16", {12'd0, busy_c, done_c, s_c, cout_c, ovf_c, zero_c}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 11; v++) begin
      run_op(tbl[v].a, tbl[v].b, tbl[v].cin, tbl[v].ans);
      check_timing();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("vec%0d s[%0d]", v, i), 32'(gs[i]), 32'(tbl[v].s));
        chk($sformatf("vec%0d cout[%0d]", v, i), 32'(gc[i]), 32'(tbl[v].cout));
        chk($sformatf("vec%0d ovf[%0d]", v, i), 32'(go[i]), 32'(tbl[v].ovf));
        chk($sformatf("vec%0d zero[%0d]", v, i), 32'(gz[i]), 32'(tbl[v].zero));
      end
      check_model(2, tbl[v].a, tbl[v].b, tbl[v].cin, tbl[v].ans);
      if (v == 5) begin
        chk("ffff_plus_1_cin_s16", 32'(gs[2]), 32'h0001);
        chk("ffff_plus_1_cin_cout16", 32'(gc[2]), 32'd1);
      end
    end

    for (int r = 0; r < 24; r++) begin
      logic [15:0] ra, rb;
      logic        rc, rn;
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rn = 1'($urandom);
      run_op(ra, rb, rc, rn);
      for (int i = 0; i < 3; i++) check_model(i, ra, rb, rc, rn);
    end

    // Held start: back-to-back op from DONE; operand edits and start pulses in RUN ignored.
    @(negedge clk);
    a_i = 16'd10; b_i = 16'd20; cin_i = 1'b0; ans_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    nd = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 3) begin a_i = 16'd50; b_i = 16'd60; end
      if (k == 10) start_i = 1'b0;
      if (k == 13) start_i = 1'b1;
      if (k == 14) start_i = 1'b0;
      @(posedge clk); #1;
      if (k == 9) chk("b2b_busy_no_gap", 32'(busy_a), 32'd1);
      if (done_a) begin
        nd++;
        if (nd == 1) begin
          chk("b2b_first_done_cycle", 32'(k), 32'd8);
          chk("b2b_first_result", 32'(s_a), 32'd30);
        end else if (nd == 2) begin
          chk("b2b_second_done_cycle", 32'(k), 32'd17);
          chk("b2b_second_result", 32'(s_a), 32'd110);
        end
      end
    end
    chk("b2b_done_count", 32'(nd), 32'd2);

    // Reset in the third RUN cycle, with start asserted alongside.
    @(negedge clk);
    a_i = 16'd200; b_i = 16'd100; cin_i = 1'b0; ans_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk); #1;
    end
    chk("abort_busy_before_rst", 32'(busy_a), 32'd1);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs_cleared", {20'd0, busy_a, done_a, s_a, cout_a, ovf_a, zero_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) bad++;
    end
    chk("abort_no_done_or_busy", 32'(bad), 32'd0);

    run_op(16'd200, 16'd100, 1'b0, 1'b1);
    check_timing();
    chk("after_abort_s8", 32'(gs[0]), 32'd44);
    chk("after_abort_cout8", 32'(gc[0]), 32'd1);
    check_model(2, 16'd200, 16'd100, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
